// File: rtl/reg_arb_pkg.sv
// ---------------------------------------------------------------------------
// reg_arb_pkg
// Shared definitions for the round-robin register write arbiter.
//   - default data width (P) and requester count (N)
//   - arbiter FSM state encoding (2 bits, code 3 is unused and recovers to IDLE)
//   - idx_width(): width of a requester index (clog2 of N, at least 1)
// ---------------------------------------------------------------------------
package reg_arb_pkg;

   localparam int REG_ARB_P_DEFAULT = 32;
   localparam int REG_ARB_N_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_ACK  = 2'd2
   } arb_state_t;

   // Width needed to hold a requester index 0..n-1; never narrower than 1 bit.
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search. Starting at (ptr+1) mod N and wrapping
// upward, returns the first requester whose request bit is set.
// Ports:
//   req   in  [N-1:0]   request vector
//   ptr   in  [IW-1:0]  index of the most recently served requester
//   gnt   out [N-1:0]   one-hot winner (all zero when valid is low)
//   idx   out [IW-1:0]  binary index of the winner
//   valid out           at least one request present
// ---------------------------------------------------------------------------
module rr_picker
   import reg_arb_pkg::*;
#(
   parameter int N  = REG_ARB_N_DEFAULT,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          valid
);

   logic [IW-1:0] cand;

   // Walk offsets 1..N from the pointer; offset N lands back on ptr itself,
   // so the last-served requester is considered only when nobody else asks.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IW'((int'(ptr) + k) % N);
         if (!valid && req[cand]) begin
            valid     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/reg_arbiter.sv
// ---------------------------------------------------------------------------
// reg_arbiter
// Round-robin write arbiter in front of one shared P-bit holding register.
// Each transaction: IDLE (arbitrate, register grant) -> LOAD (capture data
// of the granted requester into Q) -> ACK (one-cycle ACK pulse registered,
// round-robin pointer advanced). All outputs come straight from flops.
//
// Optional feature macro: REG_ARB_LOCK_EN
//   defined   : LOCK input present; a granted requester holding LOCK and REQ
//               at the end of a write keeps the grant and writes again
//               (ACK -> LOAD), pointer updated only on the final write.
//   undefined : LOCK port absent, strict round-robin.
//
// Ports:
//   CLK    in             rising-edge clock
//   RST_N  in             synchronous active-low reset
//   REQ    in  [N-1:0]    request per requester, held until its ACK
//   DATA   in  [N*P-1:0]  requester data, slice i = DATA[i*P +: P]
//   LOCK   in  [N-1:0]    burst hold request (REG_ARB_LOCK_EN only)
//   GNT    out [N-1:0]    one-hot current grant, zero when idle
//   ACK    out [N-1:0]    one-cycle write-complete pulse
//   BUSY   out            FSM not in IDLE
//   Q      out [P-1:0]    shared register contents
// ---------------------------------------------------------------------------
module reg_arbiter
   import reg_arb_pkg::*;
#(
   parameter int P = REG_ARB_P_DEFAULT,
   parameter int N = REG_ARB_N_DEFAULT
) (
   input  logic           CLK,
   input  logic           RST_N,
   input  logic [N-1:0]   REQ,
   input  logic [N*P-1:0] DATA,
`ifdef REG_ARB_LOCK_EN
   input  logic [N-1:0]   LOCK,
`endif
   output logic [N-1:0]   GNT,
   output logic [N-1:0]   ACK,
   output logic           BUSY,
   output logic [P-1:0]   Q
);

   localparam int IW = idx_width(N);

   arb_state_t    state_reg, state_next;
   logic [N-1:0]  gnt_reg,   gnt_next;
   logic [N-1:0]  ack_reg,   ack_next;
   logic [IW-1:0] win_reg,   win_next;
   logic [IW-1:0] ptr_reg,   ptr_next;
   logic [P-1:0]  q_reg,     q_next;
   logic          busy_reg,  busy_next;

   logic [N-1:0]  pick_gnt;
   logic [IW-1:0] pick_idx;
   logic          pick_valid;
   logic          burst_continue;

   // Per-requester view of the flat data bus.
   logic [P-1:0]  slice [N];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_slice
         assign slice[gi] = DATA[gi*P +: P];
      end
   endgenerate

   rr_picker #(
      .N  (N),
      .IW (IW)
   ) u_picker (
      .req   (REQ),
      .ptr   (ptr_reg),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // Burst continues only while the current winner still both requests and
   // locks; gnt_reg is one-hot so the AND isolates the winner's bits.
   always_comb begin
      burst_continue = 1'b0;
`ifdef REG_ARB_LOCK_EN
      burst_continue = |(gnt_reg & LOCK & REQ);
`endif
   end

   // Next-state and next-output logic.
   always_comb begin
      state_next = state_reg;
      gnt_next   = gnt_reg;
      ack_next   = '0;
      win_next   = win_reg;
      ptr_next   = ptr_reg;
      q_next     = q_reg;

      case (state_reg)
         ST_IDLE: begin
            // REQ is only looked at here; later changes cannot move the grant.
            if (pick_valid) begin
               gnt_next   = pick_gnt;
               win_next   = pick_idx;
               state_next = ST_LOAD;
            end else begin
               gnt_next   = '0;
            end
         end

         ST_LOAD: begin
            q_next     = slice[win_reg];
            state_next = ST_ACK;
         end

         ST_ACK: begin
            // The write is complete even if the requester already dropped REQ.
            ack_next = gnt_reg;
            if (burst_continue) begin
               state_next = ST_LOAD;
            end else begin
               ptr_next   = win_reg;
               gnt_next   = '0;
               state_next = ST_IDLE;
            end
         end

         default: begin
            gnt_next   = '0;
            state_next = ST_IDLE;
         end
      endcase

      busy_next = (state_next != ST_IDLE);
   end

   // State and output registers. Reset wins over an in-flight write.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_reg <= ST_IDLE;
         gnt_reg   <= '0;
         ack_reg   <= '0;
         win_reg   <= '0;
         ptr_reg   <= IW'(N - 1);
         q_reg     <= '0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         gnt_reg   <= gnt_next;
         ack_reg   <= ack_next;
         win_reg   <= win_next;
         ptr_reg   <= ptr_next;
         q_reg     <= q_next;
         busy_reg  <= busy_next;
      end
   end

   assign GNT  = gnt_reg;
   assign ACK  = ack_reg;
   assign BUSY = busy_reg;
   assign Q    = q_reg;

endmodule
